// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause, EPC, PRId, mtc0/mfc0/eret
// servicing and the single pipeline flush/trap strobe int_req.
module cp0_ctrl #(
   parameter logic [31:0] PRID    = 32'h2025_0007,
   parameter logic [4:0]  EXC_INT = 5'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic [5:0]  hw_int,
   input  logic        eret,
   output logic        int_req,
   output logic [31:0] epc_out
);

   typedef enum logic [4:0] {
      REG_SR    = 5'd12,
      REG_CAUSE = 5'd13,
      REG_EPC   = 5'd14,
      REG_PRID  = 5'd15
   } cp0_reg_e;

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_pend;
   logic        exc_pend;
   logic [31:0] trap_pc;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign int_pend = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
   assign exc_pend = (exc_code_in != 5'd0) & ~sr_exl;
   // Reset gating keeps the flush quiet while state is held cleared.
   assign int_req  = ~reset & (int_pend | exc_pend);

   assign trap_pc  = bd_in ? (vpc - 32'd4) : vpc;

   assign sr_word    = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
   assign cause_word = {cause_bd, 15'h0000, cause_ip, 3'b000, cause_exc, 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_im     <= '0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= '0;
         epc       <= '0;
      end else begin
         cause_ip <= hw_int;
         if (int_req) begin
            // Trap commit: the victim's own mtc0/eret are flushed with it.
            sr_exl    <= 1'b1;
            cause_bd  <= bd_in;
            cause_exc <= int_pend ? EXC_INT : exc_code_in;
            epc       <= trap_pc & ~32'd3;
         end else begin
            if (we) begin
               case (addr)
                  REG_SR: begin
                     sr_im  <= wdata[15:10];
                     sr_exl <= wdata[1];
                     sr_ie  <= wdata[0];
                  end
                  REG_EPC: epc <= wdata & ~32'd3;
                  default: ;
               endcase
            end
            if (eret)
               sr_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         REG_SR:    rdata = sr_word;
         REG_CAUSE: rdata = cause_word;
         REG_EPC:   rdata = epc;
         REG_PRID:  rdata = PRID;
         default:   rdata = '0;
      endcase
   end

   // Forward an mtc0 EPC so an eret at the next edge returns to the new value.
   assign epc_out = (we && (addr == REG_EPC)) ? (wdata & ~32'd3) : epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: stimulus queues expected values per cycle, a
// negedge monitor pops and compares them against rdata, int_req and epc_out.
module tb_cp0_ctrl;

   localparam int K_RD  = 0;
   localparam int K_IRQ = 1;
   localparam int K_EPC = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [31:0] vpc = '0;
   logic        bd_in = 1'b0;
   logic [4:0]  exc_code_in = '0;
   logic [5:0]  hw_int = '0;
   logic        eret = 1'b0;
   logic        int_req;
   logic [31:0] epc_out;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   errors = 0;
   int   checks = 0;

   cp0_ctrl #(.PRID(32'h2025_0007), .EXC_INT(5'd0)) dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
      .hw_int(hw_int), .eret(eret), .int_req(int_req), .epc_out(epc_out)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] act;
      while (sb.size() != 0) begin
         c = sb.pop_front();
         case (c.kind)
            K_RD:    act = rdata;
            K_IRQ:   act = {31'b0, int_req};
            default: act = epc_out;
         endcase
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
         end
      end
   end

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] wd,
                        input logic [31:0] pc, input logic bd, input logic [4:0] ec,
                        input logic [5:0] hw, input logic er);
      @(posedge clk);
      #1;
      we = w; addr = a; wdata = wd; vpc = pc; bd_in = bd;
      exc_code_in = ec; hw_int = hw; eret = er;
   endtask

   task automatic exp_chk(input int kind, input logic [31:0] exp, input string name);
      chk_t c;
      c.kind = kind; c.exp = exp; c.name = name;
      sb.push_back(c);
   endtask

   initial begin
      // reset held: flush gated even with an exception code present
      drive(0, 12, 0, 0, 0, 5'd5, 0, 0);
      exp_chk(K_RD, 32'h0, "sr_in_reset");
      exp_chk(K_IRQ, 32'h0, "irq_in_reset");
      exp_chk(K_EPC, 32'h0, "epc_out_in_reset");
      drive(0, 12, 0, 0, 0, 0, 0, 0); reset = 1'b0;
      exp_chk(K_RD, 32'h0, "sr_reset");
      exp_chk(K_IRQ, 32'h0, "irq_reset");
      drive(0, 13, 0, 0, 0, 0, 0, 0); exp_chk(K_RD, 32'h0, "cause_reset");
      drive(0, 14, 0, 0, 0, 0, 0, 0); exp_chk(K_RD, 32'h0, "epc_reset");
      exp_chk(K_EPC, 32'h0, "epc_out_reset");
      drive(0, 15, 0, 0, 0, 0, 0, 0); exp_chk(K_RD, 32'h2025_0007, "prid");
      drive(0, 3, 0, 0, 0, 0, 0, 0);  exp_chk(K_RD, 32'h0, "unmapped");

      // mtc0 SR then external interrupt
      drive(1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0, "sr_no_bypass");
      exp_chk(K_IRQ, 32'h0, "irq_during_sr_write");
      drive(0, 12, 0, 32'h0000_3010, 0, 0, 6'b000001, 0);
      exp_chk(K_RD, 32'h0000_0401, "sr_written");
      exp_chk(K_IRQ, 32'h1, "irq_hw");
      drive(0, 14, 0, 32'h0000_3010, 0, 0, 6'b000001, 0);
      exp_chk(K_RD, 32'h0000_3010, "epc_int");
      exp_chk(K_IRQ, 32'h0, "irq_exl_mask");
      drive(0, 13, 0, 0, 0, 0, 6'b000001, 0);
      exp_chk(K_RD, 32'h0000_0400, "cause_int");
      exp_chk(K_IRQ, 32'h0, "irq_exl_mask2");
      drive(0, 12, 0, 0, 0, 0, 6'b000001, 0);
      exp_chk(K_RD, 32'h0000_0403, "sr_exl_set");
      drive(0, 12, 0, 0, 0, 0, 6'b000001, 1);
      exp_chk(K_IRQ, 32'h0, "irq_at_eret");
      exp_chk(K_RD, 32'h0000_0403, "sr_before_eret");
      drive(0, 12, 0, 32'h0000_5000, 0, 0, 6'b000001, 0);
      exp_chk(K_IRQ, 32'h1, "irq_after_eret");
      exp_chk(K_RD, 32'h0000_0401, "sr_exl_cleared");
      drive(0, 12, 0, 0, 0, 0, 0, 1);
      exp_chk(K_IRQ, 32'h0, "irq_eret2");

      // synchronous exception in a delay slot
      drive(0, 12, 0, 32'h0000_3024, 1, 5'd4, 0, 0);
      exp_chk(K_IRQ, 32'h1, "irq_exc");
      drive(0, 14, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_3020, "epc_bd");
      exp_chk(K_IRQ, 32'h0, "irq_after_exc");
      drive(0, 13, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h8000_0010, "cause_bd_exc4");
      drive(0, 13, 0, 0, 0, 0, 0, 1);
      exp_chk(K_IRQ, 32'h0, "irq_eret3");

      // interrupt beats exception; concurrent mtc0 EPC dropped
      drive(1, 14, 32'h0000_1234, 32'h0000_6000, 0, 5'd10, 6'b000001, 0);
      exp_chk(K_IRQ, 32'h1, "irq_both");
      exp_chk(K_EPC, 32'h0000_1234, "epc_fwd_trap");
      exp_chk(K_RD, 32'h0000_3020, "epc_before_trap");
      drive(0, 13, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_0400, "cause_int_wins");
      exp_chk(K_IRQ, 32'h0, "irq_after_both");
      drive(0, 14, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_6000, "epc_mtc0_dropped");
      exp_chk(K_EPC, 32'h0000_6000, "epc_out_reg");
      drive(0, 14, 0, 0, 0, 0, 0, 1);
      exp_chk(K_IRQ, 32'h0, "irq_eret4");

      // eret together with a trap: trap wins, EXL stays set
      drive(0, 12, 0, 32'h0000_7008, 0, 5'd5, 0, 1);
      exp_chk(K_IRQ, 32'h1, "irq_over_eret");
      exp_chk(K_RD, 32'h0000_0401, "sr_pre_trap");
      drive(0, 12, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_0403, "exl_kept");
      exp_chk(K_IRQ, 32'h0, "irq_exl_kept");

      // mtc0 EPC with eret in the same cycle
      drive(1, 14, 32'h0000_3407, 0, 0, 0, 0, 1);
      exp_chk(K_EPC, 32'h0000_3404, "epc_fwd_eret");
      exp_chk(K_RD, 32'h0000_7008, "epc_no_bypass");
      drive(0, 14, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_3404, "epc_masked");
      exp_chk(K_EPC, 32'h0000_3404, "epc_out_masked");
      exp_chk(K_IRQ, 32'h0, "irq_idle");

      // read-only Cause and SR write mask
      drive(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_0014, "cause_pre_write");
      drive(0, 13, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_0014, "cause_ro");
      drive(1, 12, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_0401, "sr_pre_full_write");
      drive(0, 12, 0, 0, 0, 0, 0, 0);
      exp_chk(K_RD, 32'h0000_FC03, "sr_mask");

      // asynchronous reset in the middle of a cycle
      drive(0, 14, 0, 0, 0, 5'd3, 0, 0);
      #2 reset = 1'b1;
      exp_chk(K_RD, 32'h0, "epc_async_reset");
      exp_chk(K_EPC, 32'h0, "epc_out_async_reset");
      exp_chk(K_IRQ, 32'h0, "irq_async_reset");
      drive(0, 12, 0, 0, 0, 0, 0, 0); exp_chk(K_RD, 32'h0, "sr_async_reset");
      drive(0, 13, 0, 0, 0, 0, 0, 0); exp_chk(K_RD, 32'h0, "cause_async_reset");

      @(posedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
